// File: rtl/prv32_id_ex_stage.sv
// prv32 ID/EX pipeline register with operand forwarding,
// load-use hazard detection and bubble counting.
module prv32_id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alusrc,
    input  logic [3:0]        id_alufn,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              flush,
    input  logic [4:0]        mem_rd_addr,
    input  logic              mem_regwrite,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [4:0]        wb_rd_addr,
    input  logic              wb_regwrite,
    input  logic [XLEN-1:0]   wb_result,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_alufn,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic [CNT_W-1:0]  bubble_count
);

    logic [4:0]      rs1_addr_q;
    logic [4:0]      rs2_addr_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic            alusrc_q;
    logic [3:0]      alufn_q;
    logic            regwrite_q;
    logic            memread_q;
    logic            memwrite_q;

    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            wb_hit1;
    logic            wb_hit2;

    assign ex_regwrite = regwrite_q & ex_valid;
    assign ex_memread  = memread_q & ex_valid;
    assign ex_memwrite = memwrite_q & ex_valid;
    assign alu_alufn   = ex_valid ? alufn_q : 4'd0;

    assign stall = ex_memread & (ex_rd_addr != 5'd0) & id_valid
                 & ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr))
                 & ~flush;

    // A writeback landing this cycle is not yet visible in the regfile read
    assign wb_hit1 = wb_regwrite & (wb_rd_addr != 5'd0) & (wb_rd_addr == id_rs1_addr);
    assign wb_hit2 = wb_regwrite & (wb_rd_addr != 5'd0) & (wb_rd_addr == id_rs2_addr);
    assign cap_rs1 = wb_hit1 ? wb_result : id_rs1_data;
    assign cap_rs2 = wb_hit2 ? wb_result : id_rs2_data;

    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_regwrite && mem_rd_addr != 5'd0 && mem_rd_addr == rs1_addr_q)
            fwd_rs1 = mem_result;
        else if (wb_regwrite && wb_rd_addr != 5'd0 && wb_rd_addr == rs1_addr_q)
            fwd_rs1 = wb_result;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (mem_regwrite && mem_rd_addr != 5'd0 && mem_rd_addr == rs2_addr_q)
            fwd_rs2 = mem_result;
        else if (wb_regwrite && wb_rd_addr != 5'd0 && wb_rd_addr == rs2_addr_q)
            fwd_rs2 = wb_result;
    end

    assign alu_a         = fwd_rs1;
    assign alu_b         = alusrc_q ? imm_q : fwd_rs2;
    assign alu_shamt     = alu_b[4:0];
    assign ex_store_data = fwd_rs2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            alusrc_q     <= 1'b0;
            alufn_q      <= '0;
            ex_rd_addr   <= '0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            bubble_count <= '0;
        end else if (flush || stall) begin
            ex_valid   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            if (!flush && bubble_count != '1)
                bubble_count <= bubble_count + CNT_W'(1);
        end else begin
            ex_valid   <= id_valid;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rs1_data_q <= cap_rs1;
            rs2_data_q <= cap_rs2;
            imm_q      <= id_imm;
            alusrc_q   <= id_alusrc;
            alufn_q    <= id_alufn;
            ex_rd_addr <= id_rd_addr;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
            memwrite_q <= id_memwrite;
        end
    end

endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// Scoreboard bench for prv32_id_ex_stage: directed hazard
// scenarios followed by randomized traffic against a reference model.
module tb_prv32_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
    logic [3:0]  id_alufn;
    logic        flush;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_result, wb_result;
    logic        stall, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt, ex_rd_addr;
    logic [3:0]  alu_alufn;
    logic        ex_regwrite, ex_memread, ex_memwrite;
    logic [15:0] bubble_count;

    prv32_id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_alufn(id_alufn),
        .id_rd_addr(id_rd_addr), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .flush(flush), .mem_rd_addr(mem_rd_addr),
        .mem_regwrite(mem_regwrite), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_regwrite(wb_regwrite),
        .wb_result(wb_result), .stall(stall), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_alufn(alu_alufn), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        v;
        logic [15:0] cnt;
    } ctl_t;

    typedef struct {
        logic [31:0] a, b, st;
        logic [4:0]  sh, rd;
        logic [3:0]  fn;
        logic        rw, mr, mw;
    } ex_t;

    // Instruction the model believes is sitting in EX
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        as;
        logic [3:0]  fn;
        logic        rw, mr, mw;
    } slot_t;

    slot_t       slot, nxt;
    logic [15:0] cnt, ncnt;
    bit          last_stall;
    bit          mon_en = 0;
    ctl_t        ctlq[$];
    ex_t         exq[$];
    int          checks = 0;
    int          passes = 0;
    ctl_t        mc;
    ex_t         me;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Value of register r seen by a reader: youngest matching writer wins, x0 never written
    function automatic logic [31:0] youngest(
        input logic [4:0] r, input logic [31:0] base,
        input logic w1, input logic [4:0] a1, input logic [31:0] v1,
        input logic w2, input logic [4:0] a2, input logic [31:0] v2);
        if (r == 5'd0) return base;
        if (w1 && a1 == r) return v1;
        if (w2 && a2 == r) return v2;
        return base;
    endfunction

    task automatic idle();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alusrc = 0;
        id_alufn = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
        flush = 0; mem_rd_addr = 0; mem_regwrite = 0; mem_result = 0;
        wb_rd_addr = 0; wb_regwrite = 0; wb_result = 0;
    endtask

    task automatic drive();
        ctl_t  c;
        ex_t   e;
        logic  s;
        s = slot.v && slot.mr && slot.rd != 0 && id_valid
          && (slot.rd == id_rs1_addr || slot.rd == id_rs2_addr) && !flush;
        c.stall = s; c.v = slot.v; c.cnt = cnt;
        ctlq.push_back(c);
        if (slot.v) begin
            e.a  = youngest(slot.rs1, slot.d1, mem_regwrite, mem_rd_addr, mem_result,
                            wb_regwrite, wb_rd_addr, wb_result);
            e.st = youngest(slot.rs2, slot.d2, mem_regwrite, mem_rd_addr, mem_result,
                            wb_regwrite, wb_rd_addr, wb_result);
            e.b  = slot.as ? slot.imm : e.st;
            e.sh = e.b[4:0];
            e.fn = slot.fn; e.rd = slot.rd;
            e.rw = slot.rw; e.mr = slot.mr; e.mw = slot.mw;
            exq.push_back(e);
        end
        nxt = slot; ncnt = cnt;
        if (!rst) begin
            nxt = '{default: '0}; ncnt = 0;
        end else if (flush) begin
            nxt.v = 0;
        end else if (s) begin
            nxt.v = 0;
            if (cnt != 16'hFFFF) ncnt = cnt + 16'd1;
        end else begin
            nxt.v = id_valid; nxt.rs1 = id_rs1_addr; nxt.rs2 = id_rs2_addr;
            nxt.d1 = youngest(id_rs1_addr, id_rs1_data, wb_regwrite, wb_rd_addr,
                              wb_result, 1'b0, 5'd0, 32'd0);
            nxt.d2 = youngest(id_rs2_addr, id_rs2_data, wb_regwrite, wb_rd_addr,
                              wb_result, 1'b0, 5'd0, 32'd0);
            nxt.imm = id_imm; nxt.as = id_alusrc; nxt.fn = id_alufn;
            nxt.rd = id_rd_addr; nxt.rw = id_regwrite;
            nxt.mr = id_memread; nxt.mw = id_memwrite;
        end
        last_stall = s && rst;
    endtask

    task automatic advance();
        @(posedge clk); #1;
        slot = nxt; cnt = ncnt;
    endtask

    task automatic step();
        drive();
        advance();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (ctlq.size() == 0) begin
                chk("ctl_queue_underflow", 1, 0);
            end else begin
                mc = ctlq.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, mc.stall});
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, mc.v});
                chk("bubble_count", {16'd0, bubble_count}, {16'd0, mc.cnt});
            end
            if (ex_valid) begin
                if (exq.size() == 0) begin
                    chk("ex_queue_underflow", 1, 0);
                end else begin
                    me = exq.pop_front();
                    chk("alu_a", alu_a, me.a);
                    chk("alu_b", alu_b, me.b);
                    chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, me.sh});
                    chk("alu_alufn", {28'd0, alu_alufn}, {28'd0, me.fn});
                    chk("store_data", ex_store_data, me.st);
                    chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, me.rd});
                    chk("ex_ctl", {29'd0, ex_regwrite, ex_memread, ex_memwrite},
                        {29'd0, me.rw, me.mr, me.mw});
                end
            end else begin
                chk("idle_alufn", {28'd0, alu_alufn}, 32'd0);
                chk("idle_ctl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 32'd0);
            end
        end
    end

    task automatic load_x3();
        idle();
        id_valid = 1; id_rs1_addr = 1; id_rd_addr = 3;
        id_regwrite = 1; id_memread = 1; id_imm = 32'h8;
        id_alusrc = 1;
        step();
    endtask

    initial begin
        rst = 0;
        idle();
        id_valid = 1;
        slot = '{default: '0}; nxt = slot; cnt = 0; ncnt = 0; last_stall = 0;
        @(posedge clk); #1;
        mon_en = 1;

        // reset held with a valid instruction in ID
        for (int i = 0; i < 2; i++) begin
            drive();
            @(negedge clk);
            chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_bubbles", {16'd0, bubble_count}, 32'd0);
            chk("rst_alufn", {28'd0, alu_alufn}, 32'd0);
            advance();
        end
        rst = 1;

        // EX/MEM forwarding
        idle();
        id_valid = 1; id_rs1_addr = 5; id_rs2_addr = 5; id_rd_addr = 6;
        id_regwrite = 1; id_rs1_data = 32'h1234; id_rs2_data = 32'h5678;
        step();
        idle();
        mem_rd_addr = 5; mem_regwrite = 1; mem_result = 32'h10;
        drive();
        @(negedge clk);
        chk("memfwd_a", alu_a, 32'h10);
        chk("memfwd_b", alu_b, 32'h10);
        chk("memfwd_stall", {31'd0, stall}, 32'd0);
        advance();

        // MEM beats WB
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rd_addr = 8; id_regwrite = 1;
        step();
        idle();
        mem_rd_addr = 7; mem_regwrite = 1; mem_result = 32'hAA;
        wb_rd_addr = 7; wb_regwrite = 1; wb_result = 32'hBB;
        drive();
        @(negedge clk);
        chk("prio_a", alu_a, 32'hAA);
        advance();

        // load-use: one bubble, then WB-forwarded load data
        load_x3();
        idle();
        id_valid = 1; id_rs1_addr = 3; id_rd_addr = 4; id_regwrite = 1;
        drive();
        @(negedge clk);
        chk("lu_stall", {31'd0, stall}, 32'd1);
        advance();
        mem_rd_addr = 3; mem_regwrite = 1; mem_result = 32'h100;
        drive();
        @(negedge clk);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_count", {16'd0, bubble_count}, 32'd1);
        chk("lu_nostall", {31'd0, stall}, 32'd0);
        advance();
        idle();
        wb_rd_addr = 3; wb_regwrite = 1; wb_result = 32'hCAFE;
        drive();
        @(negedge clk);
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_a", alu_a, 32'hCAFE);
        advance();

        // flush and load-use together
        load_x3();
        idle();
        id_valid = 1; id_rs1_addr = 3; id_rd_addr = 4; flush = 1;
        drive();
        @(negedge clk);
        chk("fl_stall", {31'd0, stall}, 32'd0);
        advance();
        idle();
        drive();
        @(negedge clk);
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_count", {16'd0, bubble_count}, 32'd1);
        advance();

        // x0 is never forwarded
        idle();
        id_valid = 1; id_rd_addr = 9; id_regwrite = 1;
        step();
        idle();
        mem_regwrite = 1; mem_result = 32'hFFFF_FFFF;
        drive();
        @(negedge clk);
        chk("x0_a", alu_a, 32'd0);
        advance();

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 1500) ? 1'b0 : 1'b1;
            if (!last_stall) begin
                id_valid    = ($urandom_range(0, 5) != 0);
                id_rs1_addr = 5'($urandom_range(0, 7));
                id_rs2_addr = 5'($urandom_range(0, 7));
                id_rd_addr  = 5'($urandom_range(0, 7));
                id_rs1_data = $urandom;
                id_rs2_data = $urandom;
                id_imm      = $urandom;
                id_alusrc   = 1'($urandom_range(0, 1));
                id_alufn    = 4'($urandom_range(0, 15));
                id_regwrite = 1'($urandom_range(0, 1));
                id_memread  = ($urandom_range(0, 2) == 0);
                id_memwrite = ($urandom_range(0, 4) == 0);
            end
            flush        = ($urandom_range(0, 7) == 0);
            mem_rd_addr  = 5'($urandom_range(0, 7));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_result   = $urandom;
            wb_rd_addr   = 5'($urandom_range(0, 7));
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_result    = $urandom;
            step();
        end
        rst = 1;
        idle();
        for (int i = 0; i < 3; i++) step();
        mon_en = 0;
        chk("ex_queue_drained", exq.size(), 0);
        chk("ctl_queue_drained", ctlq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
